reg_writeback_arbiter: RTL
==========================

Name: reg_writeback_arbiter

Overview:
- Initiator side of the register-file write port.
- Merges two writeback sources, ALU results and late load returns, onto the single write port `wena`/`waddr`/`wdata`.
- Preserves program order and buffers collisions in a small FIFO.
- Exposes per-read-port pending-write hits with bypass data, so decode can forward or stall.
- Sits between the MEM/WB stage and the register file.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, width of register address.
- DEPTH, 4, pending-write FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load-return write request.
- ld_waddr  in  ADDR_W  load destination register.
- ld_wdata  in  DATA_W  load data.
- alu_valid  in  1  ALU write request.
- alu_waddr  in  ADDR_W  ALU destination register.
- alu_wdata  in  DATA_W  ALU result.
- stall  out  1  sources must not assert valid next cycle.
- ovf  out  1  sticky overflow error.
- wena  out  1  register-file write enable (registered).
- waddr  out  ADDR_W  register-file write address (registered).
- wdata  out  DATA_W  register-file write data (registered).
- r0addr  in  ADDR_W  decode read address 0.
- r1addr  in  ADDR_W  decode read address 1.
- hz0_hit  out  1  pending write to r0addr exists.
- hz0_data  out  DATA_W  youngest pending data for r0addr.
- hz1_hit  out  1  pending write to r1addr exists.
- hz1_data  out  DATA_W  youngest pending data for r1addr.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wena=0, waddr=0, wdata=0, ovf=0.
  - FIFO count=0, read/write pointers=0.
  - stall=0, hz*_hit=0, hz*_data=0.
  - FIFO storage contents are don't-care.
  - Reset mid-operation discards every pending write; no partial write is issued after reset release.
- Address-0 filter: a request with waddr==0 is discarded at input. It is never enqueued or issued, and never produces a hit.
- Candidate order each cycle, oldest first:
  - FIFO head, if count>0;
  - then the ld request (load is the older instruction);
  - then the alu request.
- Issue:
  - The first candidate is registered onto wena/waddr/wdata at the clock edge.
  - The register file commits it one edge later, so latency from input to the write port is 1 cycle.
  - If there is no candidate, wena=0 on the next cycle; waddr/wdata hold their previous values.
- Enqueue:
  - Remaining candidates (ld before alu) are pushed into the FIFO tail in that order.
  - Same-cycle pop and push are both legal.
- Net FIFO growth is at most +1 per cycle.
- Count and stall:
  - count tracks entries, 0..DEPTH.
  - stall = (count ≥ DEPTH-1), combinational from count.
- Overflow:
  - If a push finds the FIFO full, that request is dropped and ovf is set.
  - ovf stays 1 until reset.
  - FIFO contents and order are unaffected.
- Pointers wrap modulo DEPTH.
- Hazard lookup (combinational, per read port):
  - Compare the address against valid FIFO entries and against the current output stage (wena && waddr).
  - Hit if any match and the address is non-zero.
  - Data is taken from the youngest match: FIFO tail-most entry first, then the output stage.
  - The current cycle's incoming ld/alu requests are NOT included; the pipeline forwards those itself.
  - When there is no hit, data=0.
- WAW ordering: writes to the same address are issued in candidate order, so the younger value lands last.

Test Plan:
- Reset then single ALU write: alu_valid=1, addr=3, data=0xA5 at cycle 0 -> cycle 1 shows wena=1, waddr=3, wdata=0xA5; cycle 2 shows wena=0.
- Collision: ld(addr=5, data=0x11) and alu(addr=5, data=0x22) in the same cycle -> cycle 1 writes 5←0x11, cycle 2 writes 5←0x22; hz0_hit for r0addr=5 reads 0x22 in cycle 1 and 0x22 in cycle 2.
- Address-0 drop: alu_valid=1, addr=0 -> wena stays 0, FIFO count stays 0, hz hits stay 0.
- Fill and stall: dual requests on 3 consecutive cycles with DEPTH=4 -> count reaches 3, stall=1; issue order is strictly ld0, alu0, ld1, alu1, ld2, alu2 at 1 write/cycle.
- Overflow: ignore stall and keep dual-issuing until a push hits count=4 -> dropped request is never written, ovf=1 and stays 1, remaining order intact.
- Reset mid-drain: assert rst_n=0 with count=3 and wena=1 -> outputs and stall go 0 immediately; after release no queued write ever appears.

Source files
------------

// File: rtl/reg_writeback_arbiter_if.sv
// Register-file writeback bundle: two write sources in, one write port out,
// plus the decode-side hazard lookup ports.
interface reg_writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_waddr;
  logic [DATA_W-1:0] ld_wdata;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              stall;
  logic              ovf;
  logic              wena;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] r0addr;
  logic [ADDR_W-1:0] r1addr;
  logic              hz0_hit;
  logic [DATA_W-1:0] hz0_data;
  logic              hz1_hit;
  logic [DATA_W-1:0] hz1_data;

  // The arbiter side.
  modport master (
    input  ld_valid, ld_waddr, ld_wdata, alu_valid, alu_waddr, alu_wdata,
    input  r0addr, r1addr,
    output stall, ovf, wena, waddr, wdata,
    output hz0_hit, hz0_data, hz1_hit, hz1_data
  );

  // The pipeline / register-file side.
  modport slave (
    output ld_valid, ld_waddr, ld_wdata, alu_valid, alu_waddr, alu_wdata,
    output r0addr, r1addr,
    input  stall, ovf, wena, waddr, wdata,
    input  hz0_hit, hz0_data, hz1_hit, hz1_data
  );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Merges load-return and ALU writebacks onto one register-file write port in
// program order, queueing collisions and exposing pending writes for bypass.
module reg_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  reg_writeback_arbiter_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];

  logic [PTR_W-1:0]  rptr_reg, rptr_next, wptr_reg, wptr_next, wptr_inc;
  logic [CNT_W-1:0]  count_reg, count_next, base_cnt;
  logic              ovf_reg, ovf_next;
  logic              wena_reg, wena_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  logic              ld_ok, alu_ok, head_ok;
  logic              push_a_valid, push_b_valid, acc_a, acc_b;
  logic [ADDR_W-1:0] push_a_addr, push_b_addr;
  logic [DATA_W-1:0] push_a_data, push_b_data;

  // Writes to r0 are architecturally meaningless and vanish at the input.
  assign ld_ok   = bus.ld_valid  && (bus.ld_waddr  != '0);
  assign alu_ok  = bus.alu_valid && (bus.alu_waddr != '0);
  assign head_ok = (count_reg != '0);

  // Oldest candidate issues; the rest go to the tail, ld ahead of alu.
  always_comb begin
    wena_next    = 1'b0;
    waddr_next   = waddr_reg;
    wdata_next   = wdata_reg;
    push_a_valid = 1'b0;
    push_a_addr  = bus.alu_waddr;
    push_a_data  = bus.alu_wdata;
    push_b_valid = 1'b0;
    push_b_addr  = bus.alu_waddr;
    push_b_data  = bus.alu_wdata;
    if (head_ok) begin
      wena_next  = 1'b1;
      waddr_next = fifo_addr[rptr_reg];
      wdata_next = fifo_data[rptr_reg];
      if (ld_ok) begin
        push_a_valid = 1'b1;
        push_a_addr  = bus.ld_waddr;
        push_a_data  = bus.ld_wdata;
        push_b_valid = alu_ok;
      end else begin
        push_a_valid = alu_ok;
      end
    end else if (ld_ok) begin
      wena_next    = 1'b1;
      waddr_next   = bus.ld_waddr;
      wdata_next   = bus.ld_wdata;
      push_a_valid = alu_ok;
    end else if (alu_ok) begin
      wena_next  = 1'b1;
      waddr_next = bus.alu_waddr;
      wdata_next = bus.alu_wdata;
    end
  end

  // The same-cycle pop frees its slot before the pushes are accepted.
  always_comb begin
    base_cnt   = count_reg - CNT_W'(head_ok);
    acc_a      = push_a_valid && (base_cnt < DEPTH_C);
    acc_b      = push_b_valid && ((base_cnt + CNT_W'(acc_a)) < DEPTH_C);
    count_next = base_cnt + CNT_W'(acc_a) + CNT_W'(acc_b);
    rptr_next  = rptr_reg + PTR_W'(head_ok);
    wptr_inc   = wptr_reg + PTR_W'(1);
    wptr_next  = wptr_reg + PTR_W'(acc_a) + PTR_W'(acc_b);
    ovf_next   = ovf_reg | (push_a_valid && !acc_a) | (push_b_valid && !acc_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      wena_reg  <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      rptr_reg  <= rptr_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      wena_reg  <= wena_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (acc_a) begin
      fifo_addr[wptr_reg] <= push_a_addr;
      fifo_data[wptr_reg] <= push_a_data;
    end
    if (acc_b) begin
      fifo_addr[wptr_inc] <= push_b_addr;
      fifo_data[wptr_inc] <= push_b_data;
    end
  end

  // Per read port: scan output stage, then FIFO oldest to youngest so the
  // youngest match wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hz
    logic [ADDR_W-1:0] raddr;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign raddr = (gi == 0) ? bus.r0addr : bus.r1addr;

    always_comb begin
      logic [PTR_W-1:0] idx;
      hit = 1'b0;
      data = '0;
      idx = '0;
      if (wena_reg && (waddr_reg == raddr)) begin
        hit  = 1'b1;
        data = wdata_reg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rptr_reg + PTR_W'(k);
        if ((CNT_W'(k) < count_reg) && (fifo_addr[idx] == raddr)) begin
          hit  = 1'b1;
          data = fifo_data[idx];
        end
      end
      if (raddr == '0) begin
        hit  = 1'b0;
        data = '0;
      end
    end
  end

  assign bus.stall    = (count_reg >= CNT_W'(DEPTH - 1));
  assign bus.ovf      = ovf_reg;
  assign bus.wena     = wena_reg;
  assign bus.waddr    = waddr_reg;
  assign bus.wdata    = wdata_reg;
  assign bus.hz0_hit  = g_hz[0].hit;
  assign bus.hz0_data = g_hz[0].data;
  assign bus.hz1_hit  = g_hz[1].hit;
  assign bus.hz1_data = g_hz[1].data;
endmodule
